seq_ones_tx: RTL and testbench
==============================

# seq_ones_tx

Serial stimulus transmitter for the consecutive-ones detector chain. Accepts a parallel word on a load strobe and shifts it out one bit per clock, MSB first, on `data_out`, which drives the detector's serial input. In parallel it produces a per-bit golden flag (`expect_detect`) and a per-frame longest-run figure, so the verification bench and on-board self-test can check the detector without a separate model. Frames are separated by a mandatory one-cycle zero guard bit, and can be repeated back-to-back.

## Interface
- `WIDTH`, 8: frame length in bits; legal range 3..32.
- `RW`, `$clog2(WIDTH+1)`: width of `max_run`. Derived; do not override.

- `clk`  in  1  clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  start request; sampled only in IDLE.
- `word_in`  in  WIDTH  frame to transmit; captured when `load` is accepted.
- `repeat_en`  in  1  sampled in GUARD; 1 = retransmit the held word immediately.
- `data_out`  out  1  serial bit to the detector.
- `valid`  out  1  high while `data_out` carries a frame bit.
- `busy`  out  1  high in SHIFT and GUARD.
- `done`  out  1  one-cycle pulse in the GUARD cycle.
- `expect_detect`  out  1  high when the current `data_out` bit is the 3rd or later consecutive 1.
- `max_run`  out  RW  longest run of 1s in the last completed frame.

## Operation
- Moore FSM with states IDLE, SHIFT and GUARD. All outputs are registered.
- IDLE:
  - `load`=1: capture `word_in` into the shadow register and the shift register, clear the bit counter, clear the run and max accumulators, go to SHIFT.
  - `load`=0: stay in IDLE.
- SHIFT: each cycle presents the next bit, MSB first. After bit WIDTH-1 has been presented, go to GUARD.
- GUARD: lasts exactly one cycle.
  - Outputs in this cycle: `data_out`=0, `valid`=0, `done`=1, `busy`=1.
  - `max_run` updates to the frame's maximum in this cycle.
  - `repeat_en`=1: reload the shift register from the shadow register and go to SHIFT.
  - `repeat_en`=0: go to IDLE.
- `load` is ignored in SHIFT and GUARD. It is not queued.
- Run counter:
  - Saturating, `RW` bits wide.
  - Increments on each transmitted 1 and clears on each transmitted 0.
  - Cleared in GUARD and in IDLE, so runs never carry across frames.
- `expect_detect` = (`valid` & run count including the current bit ≥ 3).
- The detector's registered `detect` output equals `expect_detect` delayed by one cycle. The bench compares on that offset.
- Max accumulator: running maximum of the run counter. It is transferred to `max_run` in GUARD.
- `max_run` holds its value until the next GUARD.

## Timing
- Reset (asynchronous, active-low), any state:
  - State goes to IDLE.
  - Shadow register, shift register, bit counter, run counter, max accumulator and `max_run` clear to 0.
  - `data_out`, `valid`, `busy`, `done` and `expect_detect` go to 0.
- Reset mid-frame abandons the frame: no `done`, and `max_run` reads 0.
- Load accepted at edge T0:
  - Bit `word_in[WIDTH-1]` appears at T0+1, with `valid`=`busy`=1.
  - Bit 0 appears at T0+WIDTH.
  - GUARD/`done` occurs at T0+WIDTH+1.
  - `busy` drops at T0+WIDTH+2 when there is no repeat.
- Repeat: the next frame's first bit appears at T0+WIDTH+2. Frame period is WIDTH+1 cycles, with exactly one zero bit between frames.
- `load` held high continuously: next frame starts at T0+WIDTH+2, with `word_in` re-sampled in IDLE. Period is WIDTH+2.
- Frame of all 1s: the run counter saturates and never wraps.

## Test plan
- `word_in`=8'b1110_0000, load at T0:
  - `data_out` is 1,1,1,0,0,0,0,0 at T0+1..T0+8.
  - `expect_detect` is high only at T0+3.
  - `done` at T0+9; `max_run`=3.
- `word_in`=8'hFF:
  - `expect_detect` high at T0+3..T0+8.
  - `max_run`=8.
  - Detector `detect` is high at T0+4..T0+9.
- `word_in`=8'b1101_1011:
  - `expect_detect` never asserts.
  - `max_run`=2.
- `word_in`=8'hF0, `repeat_en`=1 for two frames:
  - Bit stream is 11110000 0 11110000.
  - `done` at T0+9 and T0+18.
  - `max_run`=4 both times.
- Load 8'hAA; pulse `load` with 8'hFF at T0+3:
  - The second load is ignored.
  - The stream remains 10101010 and `busy` stays high through T0+9.
- Load 8'hFF; assert `reset` low at T0+4:
  - All outputs go to 0 immediately.
  - State is IDLE and `max_run`=0.
  - A new load after release works normally.

Source files
------------

// File: rtl/seq_ones_tx.sv
// -----------------------------------------------------------------------------
// seq_ones_tx
//
// Serial stimulus transmitter for the consecutive-ones detector chain.
// A parallel word is captured on a load strobe and shifted out MSB first, one
// bit per clock, followed by a single zero guard bit. Alongside the stream the
// block produces a per-bit golden flag (expect_detect: the current bit is the
// third or later consecutive 1) and a per-frame longest-run figure (max_run).
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous reset, active low
//   load           in   start request, sampled only in IDLE
//   word_in        in   [WIDTH-1:0] frame captured when load is accepted
//   repeat_en      in   sampled in GUARD: 1 = retransmit the held word at once
//   data_out       out  serial bit to the detector
//   valid          out  data_out carries a frame bit
//   busy           out  high while shifting and in the guard cycle
//   done           out  one-cycle pulse in the guard cycle
//   expect_detect  out  current bit is the 3rd or later consecutive 1
//   max_run        out  [RW-1:0] longest run of 1s in the last completed frame
//
// All outputs are registered and reflect the action taken by the state that
// was active at the most recent clock edge. Hence the first bit of a frame
// appears one edge after the load is accepted, and busy drops on the edge
// where IDLE is processed after the guard cycle.
// -----------------------------------------------------------------------------
module seq_ones_tx #(
  parameter int WIDTH = 8,
  parameter int RW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word_in,
  input  logic             repeat_en,
  output logic             data_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             expect_detect,
  output logic [RW-1:0]    max_run
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shadow_reg;   // held copy of the frame for repeats
  logic [WIDTH-1:0] shift_reg;    // MSB is the next bit to present
  logic [CW-1:0]    cnt_reg;      // index of the bit being presented
  logic [RW-1:0]    run_reg;      // run length up to the last presented bit
  logic [RW-1:0]    max_acc_reg;  // running maximum within the current frame

  logic          bit_now;
  logic [RW-1:0] run_next;
  logic [RW-1:0] max_next;

  // Run length including the bit about to be presented. Saturates so an
  // all-ones frame can never wrap back to a small count.
  always_comb begin
    bit_now  = shift_reg[WIDTH-1];
    run_next = '0;
    if (bit_now) begin
      if (run_reg == {RW{1'b1}}) begin
        run_next = run_reg;
      end else begin
        run_next = run_reg + RW'(1);
      end
    end
    max_next = (run_next > max_acc_reg) ? run_next : max_acc_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shadow_reg    <= '0;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      run_reg       <= '0;
      max_acc_reg   <= '0;
      max_run       <= '0;
      data_out      <= 1'b0;
      valid         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      expect_detect <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          data_out      <= 1'b0;
          valid         <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
          expect_detect <= 1'b0;
          run_reg       <= '0;
          if (load) begin
            shadow_reg  <= word_in;
            shift_reg   <= word_in;
            cnt_reg     <= '0;
            max_acc_reg <= '0;
            state_reg   <= SHIFT;
          end
        end

        SHIFT: begin
          data_out      <= bit_now;
          valid         <= 1'b1;
          busy          <= 1'b1;
          done          <= 1'b0;
          expect_detect <= (run_next >= RW'(3));
          run_reg       <= run_next;
          max_acc_reg   <= max_next;
          shift_reg     <= shift_reg << 1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= GUARD;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        GUARD: begin
          // Zero guard bit; publish the frame maximum and start afresh so
          // neither the run nor the maximum leaks into the next frame.
          data_out      <= 1'b0;
          valid         <= 1'b0;
          busy          <= 1'b1;
          done          <= 1'b1;
          expect_detect <= 1'b0;
          max_run       <= max_acc_reg;
          run_reg       <= '0;
          max_acc_reg   <= '0;
          if (repeat_en) begin
            shift_reg <= shadow_reg;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ones_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_ones_tx
//
// Directed bench for seq_ones_tx (WIDTH = 8). Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point, i.e. well away from
// the next active edge. Expected streams, detect masks and run lengths are
// written out by hand per frame; each check is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_seq_ones_tx;

  localparam int WIDTH = 8;
  localparam int RW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] word_in;
  logic             repeat_en;
  logic             data_out;
  logic             valid;
  logic             busy;
  logic             done;
  logic             expect_detect;
  logic [RW-1:0]    max_run;

  int checks = 0;
  int errors = 0;

  seq_ones_tx #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .word_in       (word_in),
    .repeat_en     (repeat_en),
    .data_out      (data_out),
    .valid         (valid),
    .busy          (busy),
    .done          (done),
    .expect_detect (expect_detect),
    .max_run       (max_run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word with load high across one edge (edge T0), then drop load.
  task automatic start(input logic [7:0] w);
    load    = 1'b1;
    word_in = w;
    tick();
    load    = 1'b0;
  endtask

  // Check the eight bits T0+1..T0+8 and the guard cycle T0+9.
  task automatic frame(input logic [7:0] w, input logic [7:0] ed,
                       input logic [3:0] mx, input logic rep);
    repeat_en = rep;
    for (int i = 7; i >= 0; i--) begin
      tick();
      chk("data_out", data_out, w[i]);
      chk("valid", valid, 1'b1);
      chk("expect_detect", expect_detect, ed[i]);
      chk("busy_shift", busy, 1'b1);
      chk("done_shift", done, 1'b0);
    end
    tick();
    chk("guard_done", done, 1'b1);
    chk("guard_data", data_out, 1'b0);
    chk("guard_valid", valid, 1'b0);
    chk("guard_busy", busy, 1'b1);
    chk("guard_max_run", max_run, mx);
    $display("frame word=%h max_run=%0d repeat=%0d", w, max_run, rep);
  endtask

  logic [7:0] w_aa;

  initial begin
    reset     = 1'b0;
    load      = 1'b0;
    word_in   = '0;
    repeat_en = 1'b0;
    #2;
    chk("rst_data", data_out, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ed", expect_detect, 1'b0);
    chk("rst_max_run", max_run, 4'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // 1110_0000: detect only on third bit, max 3
    start(8'hE0);
    frame(8'hE0, 8'b0010_0000, 4'd3, 1'b0);
    tick();
    chk("e0_busy_drop", busy, 1'b0);
    chk("e0_done_drop", done, 1'b0);
    chk("e0_max_hold", max_run, 4'd3);

    // All ones: detect bits 3..8, max 8 (no wrap)
    start(8'hFF);
    frame(8'hFF, 8'b0011_1111, 4'd8, 1'b0);
    tick();
    chk("ff_busy_drop", busy, 1'b0);

    // 1101_1011: runs of two only
    start(8'hDB);
    frame(8'hDB, 8'b0000_0000, 4'd2, 1'b0);
    tick();

    // 1111_0000 repeated back-to-back
    start(8'hF0);
    frame(8'hF0, 8'b0011_0000, 4'd4, 1'b1);
    frame(8'hF0, 8'b0011_0000, 4'd4, 1'b0);
    tick();
    chk("rep_busy_drop", busy, 1'b0);
    chk("rep_valid", valid, 1'b0);

    // 1010_1010 with a stray load of FF at T0+3: ignored, not queued
    w_aa = 8'hAA;
    start(w_aa);
    repeat_en = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      load    = (i == 5);
      word_in = (i == 5) ? 8'hFF : w_aa;
      tick();
      chk("aa_data", data_out, w_aa[i]);
      chk("aa_busy", busy, 1'b1);
    end
    load = 1'b0;
    tick();
    chk("aa_done", done, 1'b1);
    chk("aa_busy_guard", busy, 1'b1);
    chk("aa_max_run", max_run, 4'd1);
    $display("frame word=aa with ignored load, max_run=%0d", max_run);
    tick();
    chk("aa_busy_drop", busy, 1'b0);
    tick();
    chk("aa_not_queued", valid, 1'b0);
    chk("aa_not_queued_busy", busy, 1'b0);

    // load held high: frame 81, then E7 re-sampled in IDLE (period 10)
    load    = 1'b1;
    word_in = 8'h81;
    tick();
    word_in = 8'hE7;
    frame(8'h81, 8'b0000_0000, 4'd1, 1'b0);
    tick();
    chk("hold_idle_valid", valid, 1'b0);
    chk("hold_idle_busy", busy, 1'b0);
    load = 1'b0;
    frame(8'hE7, 8'b0010_0001, 4'd3, 1'b0);
    tick();

    // Reset mid-frame
    start(8'hFF);
    tick();
    tick();
    tick();
    chk("pre_rst_ed", expect_detect, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_data", data_out, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ed", expect_detect, 1'b0);
    chk("mid_rst_max_run", max_run, 4'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_idle_valid", valid, 1'b0);
    chk("post_rst_done", done, 1'b0);
    $display("reset mid-frame: outputs cleared");

    start(8'hE0);
    frame(8'hE0, 8'b0010_0000, 4'd3, 1'b0);
    tick();
    chk("post_rst_busy_drop", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
